// File: rtl/chiptune_pkg.sv
// Shared types and constants for the chiptune voice engine: note-field layout,
// waveform encoding, per-octave phase increments and the noise LFSR step.
package chiptune_pkg;

    typedef enum logic [1:0] {
        WAVE_SQR   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_TRIG = 1'b1
    } seq_state_t;

    // One channel's byte in note_data, MSB first: {trig, wave[1:0], oct[1:0], note[2:0]}
    typedef struct packed {
        logic       trig;
        wave_t      wave;
        logic [1:0] oct;
        logic [2:0] note;
    } note_t;

    localparam int NOTE_LSB = 0;
    localparam int OCT_LSB  = 3;
    localparam int WAVE_LSB = 5;
    localparam int TRIG_BIT = 7;
    localparam int FIELD_W  = 8;

    localparam logic [7:0] NOTE_INC [0:7] = '{
        8'd86, 8'd91, 8'd97, 8'd102, 8'd108, 8'd115, 8'd122, 8'd129
    };

    localparam logic [14:0] LFSR_SEED = 15'h0001;

    // Fibonacci form of x^15 + x^14 + 1, shifting towards the MSB
    function automatic logic [14:0] lfsr_step(input logic [14:0] cur);
        return {cur[13:0], cur[14] ^ cur[13]};
    endfunction

endpackage

// File: rtl/chiptune_voice.sv
// One synthesiser voice: phase accumulator, envelope, noise LFSR and the
// combinational waveform shaper feeding the mixer.
module chiptune_voice
    import chiptune_pkg::*;
#(
    parameter int         PHASE_W = 16,
    parameter int         VOL_W   = 6,
    parameter logic [3:0] DECAY   = 4'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_stb,
    input  logic             decay_en,
    input  logic             seq_trig,
    input  note_t            note,
    output logic [VOL_W-1:0] voice_out
);

    localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [VOL_W-1:0]   vol_q, vol_d;
    logic [14:0]        lfsr_q, lfsr_d;
    logic               sb_prev_q, sb_prev_d;
    logic [4:0]         win_s;
    logic [3:0]         tri_s;
    logic [VOL_W+3:0]   tri_prod_s;

    // Five-bit window whose MSB is the octave-selected raw bit
    always_comb begin
        case (note.oct)
            2'd0:    win_s = phase_q[PHASE_W-1 -: 5];
            2'd1:    win_s = phase_q[PHASE_W-2 -: 5];
            2'd2:    win_s = phase_q[PHASE_W-3 -: 5];
            2'd3:    win_s = phase_q[PHASE_W-4 -: 5];
            default: win_s = phase_q[PHASE_W-1 -: 5];
        endcase
        tri_s      = win_s[4] ? ~win_s[3:0] : win_s[3:0];
        tri_prod_s = {{VOL_W{1'b0}}, tri_s} * {4'b0000, vol_q};
    end

    // Next-state for phase, envelope (trigger beats decay) and noise
    always_comb begin
        sb_prev_d = win_s[4];
        if (sample_stb) begin
            phase_d = phase_q + {{(PHASE_W-8){1'b0}}, NOTE_INC[note.note]};
        end else begin
            phase_d = phase_q;
        end
        if (seq_trig && note.trig) begin
            vol_d = VOL_MAX;
        end else if (decay_en) begin
            vol_d = vol_q - (vol_q >> DECAY);
        end else begin
            vol_d = vol_q;
        end
        if (win_s[4] && !sb_prev_q) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Voice state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= {PHASE_W{1'b0}};
            vol_q     <= {VOL_W{1'b0}};
            lfsr_q    <= LFSR_SEED;
            sb_prev_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            vol_q     <= vol_d;
            lfsr_q    <= lfsr_d;
            sb_prev_q <= sb_prev_d;
        end
    end

    // Waveform shaping; the mixer registers the result
    always_comb begin
        case (note.wave)
            WAVE_SQR:   voice_out = win_s[4] ? vol_q : {VOL_W{1'b0}};
            WAVE_PULSE: voice_out = (win_s[4] && win_s[3]) ? vol_q : {VOL_W{1'b0}};
            WAVE_TRI:   voice_out = tri_prod_s[VOL_W+3:4];
            WAVE_NOISE: voice_out = lfsr_q[0] ? vol_q : {VOL_W{1'b0}};
            default:    voice_out = {VOL_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/chiptune_voice_engine.sv
// N-voice chiptune engine: song sequencer FSM stepping on frame ticks,
// per-voice generators, registered mixer and first-order sigma-delta PWM.
module chiptune_voice_engine
    import chiptune_pkg::*;
#(
    parameter int                  NUM_CH         = 3,
    parameter int                  PHASE_W        = 16,
    parameter int                  VOL_W          = 6,
    parameter int                  SONG_LEN       = 288,
    parameter int                  TICKS_PER_BEAT = 6,
    parameter logic [4*NUM_CH-1:0] CH_DECAY       = {4'd2, 4'd2, 4'd3}
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  run,
    input  logic                                  sample_stb,
    input  logic                                  tick_stb,
    input  logic [NUM_CH-1:0]                     mute,
    output logic [$clog2(SONG_LEN)-1:0]           song_addr,
    input  logic [8*NUM_CH-1:0]                   note_data,
    output logic [VOL_W+$clog2(NUM_CH)-1:0]       mix_out,
    output logic                                  audio_pwm
);

    localparam int SA_W   = $clog2(SONG_LEN);
    localparam int MIX_W  = VOL_W + $clog2(NUM_CH);
    localparam int BEAT_W = $clog2(TICKS_PER_BEAT);
    localparam logic [SA_W-1:0]   ADDR_LAST = SA_W'(SONG_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS_PER_BEAT - 1);

    seq_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SA_W-1:0]   song_addr_q, song_addr_d;
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic [MIX_W-1:0]  pwm_acc_q, pwm_acc_d;
    logic              pwm_q, pwm_d;
    logic [MIX_W:0]    acc_sum_s;
    logic              beat_wrap_s;
    logic              decay_en_s;
    logic              seq_trig_s;
    note_t             notes_s [NUM_CH];
    logic [VOL_W-1:0]  voice_out_s [NUM_CH];

    // Sequencer next-state: a beat boundary moves the song and opens TRIG
    always_comb begin
        beat_wrap_s = tick_stb && run && (beat_q == BEAT_LAST);
        decay_en_s  = tick_stb && !beat_wrap_s;
        seq_trig_s  = (state_q == SEQ_TRIG);
        if (beat_wrap_s) begin
            beat_d      = {BEAT_W{1'b0}};
            song_addr_d = (song_addr_q == ADDR_LAST) ? {SA_W{1'b0}}
                                                     : song_addr_q + {{(SA_W-1){1'b0}}, 1'b1};
        end else if (tick_stb && run) begin
            beat_d      = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
            song_addr_d = song_addr_q;
        end else begin
            beat_d      = beat_q;
            song_addr_d = song_addr_q;
        end
        case (state_q)
            SEQ_IDLE: state_d = beat_wrap_s ? SEQ_TRIG : SEQ_IDLE;
            SEQ_TRIG: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    // Sequencer FSM and position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            beat_q      <= {BEAT_W{1'b0}};
            song_addr_q <= ADDR_LAST;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            song_addr_q <= song_addr_d;
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            assign notes_s[gc] = note_t'(note_data[gc*FIELD_W +: FIELD_W]);

            chiptune_voice #(
                .PHASE_W (PHASE_W),
                .VOL_W   (VOL_W),
                .DECAY   (CH_DECAY[gc*4 +: 4])
            ) u_voice (
                .clk        (clk),
                .rst_n      (rst_n),
                .sample_stb (sample_stb),
                .decay_en   (decay_en_s),
                .seq_trig   (seq_trig_s),
                .note       (notes_s[gc]),
                .voice_out  (voice_out_s[gc])
            );
        end
    endgenerate

    // Mixer sum and sigma-delta accumulation; MIX_W is sized to never overflow
    always_comb begin
        mix_d = {MIX_W{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (!mute[c]) begin
                mix_d = mix_d + MIX_W'(voice_out_s[c]);
            end else begin
                mix_d = mix_d;
            end
        end
        acc_sum_s = {1'b0, pwm_acc_q} + {1'b0, mix_q};
        pwm_d     = acc_sum_s[MIX_W];
        pwm_acc_d = acc_sum_s[MIX_W-1:0];
    end

    // Mixer and PWM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_q     <= {MIX_W{1'b0}};
            pwm_acc_q <= {MIX_W{1'b0}};
            pwm_q     <= 1'b0;
        end else begin
            mix_q     <= mix_d;
            pwm_acc_q <= pwm_acc_d;
            pwm_q     <= pwm_d;
        end
    end

    assign song_addr = song_addr_q;
    assign mix_out   = mix_q;
    assign audio_pwm = pwm_q;

endmodule

// File: tb/tb_chiptune_voice_engine.sv
// Self-checking bench for chiptune_voice_engine: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_chiptune_voice_engine;

    localparam int NUM_CH   = 3;
    localparam int PHASE_W  = 16;
    localparam int VOL_W    = 6;
    localparam int SONG_LEN = 288;
    localparam int TPB      = 6;
    localparam int MIX_W    = VOL_W + $clog2(NUM_CH);
    localparam int PH_MOD   = 1 << PHASE_W;
    localparam int VMAX     = (1 << VOL_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    run = 1'b0;
    logic                    sample_stb = 1'b0;
    logic                    tick_stb = 1'b0;
    logic [NUM_CH-1:0]       mute = '0;
    logic [8:0]              song_addr;
    logic [8*NUM_CH-1:0]     note_data;
    logic [MIX_W-1:0]        mix_out;
    logic                    audio_pwm;

    logic [8*NUM_CH-1:0]     rom [SONG_LEN];
    assign note_data = rom[song_addr];

    always #5 clk = ~clk;

    chiptune_voice_engine #(
        .NUM_CH         (NUM_CH),
        .PHASE_W        (PHASE_W),
        .VOL_W          (VOL_W),
        .SONG_LEN       (SONG_LEN),
        .TICKS_PER_BEAT (TPB),
        .CH_DECAY       ({4'd2, 4'd2, 4'd3})
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .sample_stb (sample_stb),
        .tick_stb   (tick_stb),
        .mute       (mute),
        .song_addr  (song_addr),
        .note_data  (note_data),
        .mix_out    (mix_out),
        .audio_pwm  (audio_pwm)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    int inc_tab [8] = '{86, 91, 97, 102, 108, 115, 122, 129};
    int dec_tab [NUM_CH] = '{3, 2, 2};

    int m_phase [NUM_CH];
    int m_vol   [NUM_CH];
    int m_lfsr  [NUM_CH];
    int m_sbp   [NUM_CH];
    int m_beat, m_addr, m_trig, m_mix, m_acc, m_pwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = 0; m_vol[c] = 0; m_lfsr[c] = 1; m_sbp[c] = 0;
        end
        m_beat = 0; m_addr = SONG_LEN - 1; m_trig = 0;
        m_mix = 0; m_acc = 0; m_pwm = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int f, note, oct, wave, trig, pos, sb, lower, win, t, out, mix, acc, fb;
        bit wrap;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wrap = tick_stb && run && (m_beat + 1 == TPB);
        mix = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            f     = int'(rom[m_addr] >> (8 * c)) & 255;
            note  = f % 8;
            oct   = (f / 8) % 4;
            wave  = (f / 32) % 4;
            trig  = f / 128;
            pos   = PHASE_W - 1 - oct;
            sb    = (m_phase[c] >> pos) & 1;
            lower = (m_phase[c] >> (pos - 1)) & 1;
            win   = (m_phase[c] >> (pos - 4)) % 32;
            t     = (win >= 16) ? 15 - (win % 16) : win % 16;
            case (wave)
                0:       out = sb ? m_vol[c] : 0;
                1:       out = (sb && lower) ? m_vol[c] : 0;
                2:       out = (t * m_vol[c]) / 16;
                default: out = (m_lfsr[c] % 2) ? m_vol[c] : 0;
            endcase
            if (!mute[c]) mix += out;
            if (sb == 1 && m_sbp[c] == 0) begin
                fb = ((m_lfsr[c] >> 14) ^ (m_lfsr[c] >> 13)) & 1;
                m_lfsr[c] = ((m_lfsr[c] * 2) + fb) % 32768;
            end
            m_sbp[c] = sb;
            if (sample_stb) m_phase[c] = (m_phase[c] + inc_tab[note]) % PH_MOD;
            if (m_trig == 1 && trig == 1) m_vol[c] = VMAX;
            else if (tick_stb && !wrap) m_vol[c] = m_vol[c] - (m_vol[c] >> dec_tab[c]);
        end
        acc   = m_acc + m_mix;
        m_pwm = acc / (1 << MIX_W);
        m_acc = acc % (1 << MIX_W);
        m_mix = mix;
        if (tick_stb && run) begin
            if (wrap) begin
                m_beat = 0;
                m_addr = (m_addr + 1) % SONG_LEN;
            end else begin
                m_beat++;
            end
        end
        m_trig = wrap ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("song_addr", 32'(song_addr), m_addr);
        chk("mix_out", 32'(mix_out), m_mix);
        chk("audio_pwm", 32'(audio_pwm), m_pwm);
    endtask

    task automatic tick_once();
        tick_stb = 1'b1;
        step();
        tick_stb = 1'b0;
        step();
    endtask

    initial begin
        int ones;
        for (int i = 0; i < SONG_LEN; i++) rom[i] = 24'($urandom);
        rom[0][7] = 1'b1;
        rom[1][7] = 1'b1;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("reset_addr", 32'(song_addr), SONG_LEN - 1);
        rst_n = 1'b1;

        // First beat: 287 wraps to 0 on the sixth tick, ch0 triggered
        run = 1'b1;
        for (int i = 0; i < TPB - 1; i++) tick_once();
        tick_stb = 1'b1;
        step();
        tick_stb = 1'b0;
        chk("wrap_to_0", 32'(song_addr), 0);
        step();
        chk("trig_vol", 32'(dut.g_ch[0].u_voice.vol_q), VMAX);

        // Decay with shift 3: 63 -> 56 -> 49 -> 43
        tick_once(); chk("decay1", 32'(dut.g_ch[0].u_voice.vol_q), 56);
        tick_once(); chk("decay2", 32'(dut.g_ch[0].u_voice.vol_q), 49);
        tick_once(); chk("decay3", 32'(dut.g_ch[0].u_voice.vol_q), 43);
        tick_once(); tick_once();
        chk("decay5", 32'(dut.g_ch[0].u_voice.vol_q), m_vol[0]);
        // Beat boundary, then a tick landing in TRIG: trigger wins
        tick_stb = 1'b1;
        step();
        step();
        tick_stb = 1'b0;
        chk("trig_over_decay", 32'(dut.g_ch[0].u_voice.vol_q), VMAX);
        chk("addr_1", 32'(song_addr), 1);

        // Phase accumulation from a fresh reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        run = 1'b0;
        rom[SONG_LEN-1][7:0] = 8'h00;
        sample_stb = 1'b1;
        repeat (100) step();
        sample_stb = 1'b0;
        chk("phase_8600", 32'(dut.g_ch[0].u_voice.phase_q), 8600);

        // Square at full volume with the raw bit high: PWM duty 63/256
        rom[0][7:0] = 8'h90;
        mute = 3'b110;
        run = 1'b1;
        for (int i = 0; i < TPB; i++) tick_once();
        repeat (4) step();
        chk("mix_63", 32'(mix_out), 63);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            ones += int'(audio_pwm);
        end
        chk("pwm_duty", 32'(ones), 63);

        // Sequencer frozen with run=0 while decay continues
        run = 1'b0;
        for (int i = 0; i < 20; i++) tick_once();
        chk("frozen_addr", 32'(song_addr), 0);
        chk("frozen_decay", 32'(dut.g_ch[0].u_voice.vol_q), m_vol[0]);
        run = 1'b1;
        for (int i = 0; i < TPB - 1; i++) tick_once();
        chk("beat_held", 32'(song_addr), 0);
        tick_once();
        chk("beat_resume", 32'(song_addr), 1);

        // Randomized traffic
        mute = '0;
        for (int i = 0; i < 3000; i++) begin
            run        = ($urandom_range(0, 3) != 0);
            tick_stb   = ($urandom_range(0, 3) == 0);
            sample_stb = ($urandom_range(0, 1) == 1);
            if (i % 256 == 0) mute = NUM_CH'($urandom);
            step();
        end
        tick_stb = 1'b0;
        sample_stb = 1'b0;
        mute = '0;

        // Reset asserted in the TRIG cycle
        run = 1'b1;
        rom[(m_addr + 1) % SONG_LEN][7] = 1'b1;
        for (int i = 0; i < TPB + 1 && m_trig == 0; i++) begin
            tick_stb = 1'b1;
            step();
        end
        tick_stb = 1'b0;
        chk("in_trig", 32'(m_trig), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_pwm", 32'(audio_pwm), 0);
        chk("rst_mix", 32'(mix_out), 0);
        chk("rst_addr", 32'(song_addr), SONG_LEN - 1);
        step();
        chk("rst_no_trig", 32'(dut.g_ch[0].u_voice.vol_q), 0);
        rst_n = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
